// File: rtl/pipe_preif.sv
// Pre-IF stage: chooses the next fetch PC, issues it to the instruction SRAM and
// hands it to IF, keeping it held or buffering redirects when either side stalls.
module pipe_preif #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        to_allowin,
    output logic        to_valid,
    output logic [31:0] pc,
    output logic        adef,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ertn_flush,
    input  logic [31:0] era,
    input  logic        ex_flush,
    input  logic [31:0] ex_entry,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    output logic        to_cancel
);

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    state_e      state_q;
    logic [31:0] last_pc_q;
    logic        redir_valid_q;
    logic [31:0] redir_pc_q;
    logic [31:0] held_pc_q;
    logic        held_adef_q;

    logic        redir_any_s;
    logic [31:0] redir_tgt_s;
    logic [31:0] nextpc_s;
    logic        nextpc_mis_s;
    logic        handshake_s;

    // Redirect selection (exception > ertn > branch) and next fetch address.
    always_comb begin
        redir_any_s = ex_flush | ertn_flush | br_taken;
        redir_tgt_s = br_target;
        if (ex_flush) begin
            redir_tgt_s = ex_entry;
        end else if (ertn_flush) begin
            redir_tgt_s = era;
        end else begin
            redir_tgt_s = br_target;
        end
        if (redir_any_s) begin
            nextpc_s = redir_tgt_s;
        end else if (redir_valid_q) begin
            nextpc_s = redir_pc_q;
        end else begin
            nextpc_s = last_pc_q + 32'd4;
        end
        nextpc_mis_s = (nextpc_s[1:0] != 2'b00);
    end

    // Outputs are combinational so a PC is offered in the same cycle addr_ok arrives.
    always_comb begin
        inst_sram_req  = 1'b0;
        inst_sram_addr = nextpc_s;
        pc             = RESET_PC;
        adef           = 1'b0;
        to_valid       = 1'b0;
        to_cancel      = 1'b0;
        handshake_s    = 1'b0;
        if (reset) begin
            inst_sram_req = 1'b0;
        end else if (state_q == S_REQ) begin
            inst_sram_req = !nextpc_mis_s;
            pc            = nextpc_s;
            adef          = nextpc_mis_s;
            // A misaligned PC never touches the SRAM and goes straight to IF.
            handshake_s   = (!nextpc_mis_s && inst_sram_addr_ok) || nextpc_mis_s;
            to_valid      = handshake_s;
        end else begin
            inst_sram_addr = held_pc_q;
            pc             = held_pc_q;
            adef           = held_adef_q;
            to_valid       = !redir_any_s;
            to_cancel      = redir_any_s && !held_adef_q;
        end
    end

    // State machine and PC bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_REQ;
            last_pc_q     <= RESET_PC - 32'd4;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'd0;
            held_pc_q     <= 32'd0;
            held_adef_q   <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (handshake_s) begin
                        last_pc_q     <= nextpc_s;
                        redir_valid_q <= 1'b0;
                        if (!to_allowin) begin
                            held_pc_q   <= nextpc_s;
                            held_adef_q <= nextpc_mis_s;
                            state_q     <= S_HOLD;
                        end else begin
                            state_q <= S_REQ;
                        end
                    end else if (redir_any_s) begin
                        redir_valid_q <= 1'b1;
                        redir_pc_q    <= redir_tgt_s;
                    end else begin
                        state_q <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (redir_any_s) begin
                        redir_valid_q <= 1'b1;
                        redir_pc_q    <= redir_tgt_s;
                        state_q       <= S_REQ;
                    end else if (to_allowin) begin
                        state_q <= S_REQ;
                    end else begin
                        state_q <= S_HOLD;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_preif.sv
// Self-checking bench for pipe_preif: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the fetch-PC rules.
module tb_pipe_preif;

    localparam logic [31:0] RST_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        to_allowin;
    logic        to_valid;
    logic [31:0] pc;
    logic        adef;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ertn_flush;
    logic [31:0] era;
    logic        ex_flush;
    logic [31:0] ex_entry;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        to_cancel;

    int checks = 0;
    int errors = 0;

    pipe_preif #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .to_allowin(to_allowin), .to_valid(to_valid),
        .pc(pc), .adef(adef), .br_taken(br_taken), .br_target(br_target),
        .ertn_flush(ertn_flush), .era(era), .ex_flush(ex_flush), .ex_entry(ex_entry),
        .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok), .to_cancel(to_cancel)
    );

    always #5 clk = ~clk;

    // Reference model: "waiting" means a PC has been handed over but IF has not taken it.
    bit          m_waiting;
    logic [31:0] m_prev;
    bit          m_pending;
    logic [31:0] m_pending_pc;
    logic [31:0] m_wait_pc;
    bit          m_wait_bad;

    bit          e_valid, e_req, e_adef, e_cancel, e_accept, e_redir;
    logic [31:0] e_pc, e_addr, e_tgt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input bit ok, input bit allow);
        inst_sram_addr_ok = ok;
        to_allowin        = allow;
        br_taken = 1'b0; ertn_flush = 1'b0; ex_flush = 1'b0;
    endtask

    // Evaluate expected outputs for the current inputs and compare.
    task automatic cyc();
        logic [31:0] cand;
        #2;
        e_redir = ex_flush || ertn_flush || br_taken;
        e_tgt   = ex_flush ? ex_entry : (ertn_flush ? era : br_target);
        cand    = e_redir ? e_tgt : (m_pending ? m_pending_pc : m_prev + 32'd4);
        e_cancel = 1'b0; e_accept = 1'b0; e_addr = cand;
        if (reset) begin
            e_valid = 1'b0; e_req = 1'b0; e_adef = 1'b0; e_pc = RST_PC;
        end else if (!m_waiting) begin
            e_adef   = (cand % 4) != 0;
            e_req    = !e_adef;
            e_pc     = cand;
            e_accept = (e_req && inst_sram_addr_ok) || e_adef;
            e_valid  = e_accept;
        end else begin
            e_req    = 1'b0;
            e_pc     = m_wait_pc;
            e_adef   = m_wait_bad;
            e_valid  = !e_redir;
            e_cancel = e_redir && !m_wait_bad;
        end
        chk("to_valid", {31'd0, to_valid}, {31'd0, e_valid});
        chk("req", {31'd0, inst_sram_req}, {31'd0, e_req});
        chk("cancel", {31'd0, to_cancel}, {31'd0, e_cancel});
        chk("adef", {31'd0, adef}, {31'd0, e_adef});
        chk("pc", pc, e_pc);
        if (e_req) chk("addr", inst_sram_addr, e_addr);
    endtask

    // Advance one clock and apply the model's state change.
    task automatic adv();
        @(posedge clk);
        if (reset) begin
            m_waiting = 1'b0; m_prev = RST_PC - 32'd4; m_pending = 1'b0;
            m_pending_pc = 32'd0; m_wait_pc = 32'd0; m_wait_bad = 1'b0;
        end else if (!m_waiting) begin
            if (e_accept) begin
                m_prev = e_pc; m_pending = 1'b0;
                if (!to_allowin) begin
                    m_waiting = 1'b1; m_wait_pc = e_pc; m_wait_bad = e_adef;
                end
            end else if (e_redir) begin
                m_pending = 1'b1; m_pending_pc = e_tgt;
            end
        end else if (e_redir) begin
            m_pending = 1'b1; m_pending_pc = e_tgt; m_waiting = 1'b0;
        end else if (to_allowin) begin
            m_waiting = 1'b0;
        end
        #1;
    endtask

    initial begin
        br_target = 32'd0; era = 32'd0; ex_entry = 32'd0;
        reset = 1'b1; set_in(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin cyc(); adv(); end
        reset = 1'b0;

        // Back-to-back fetch from the reset vector.
        for (int i = 0; i < 4; i++) begin
            cyc(); chk("seq_addr", inst_sram_addr, RST_PC + 32'(4 * i)); adv();
        end
        // IF stalls: PC 1c000010 is held for three cycles.
        set_in(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(); chk("hold_pc", pc, 32'h1c000010); adv();
        end
        chk("hold_req", {31'd0, inst_sram_req}, 32'd0);
        to_allowin = 1'b1; cyc(); adv();
        cyc(); chk("after_hold", inst_sram_addr, 32'h1c000014); adv();

        // Branch while the SRAM is busy: target buffered until accepted.
        set_in(1'b0, 1'b1); br_taken = 1'b1; br_target = 32'h1c000100; cyc(); adv();
        set_in(1'b0, 1'b1); cyc(); chk("buf_valid", {31'd0, to_valid}, 32'd0); adv();
        set_in(1'b1, 1'b1); cyc(); chk("buf_addr", inst_sram_addr, 32'h1c000100); adv();

        // Exception beats branch while holding.
        set_in(1'b1, 1'b0); cyc(); adv();
        set_in(1'b1, 1'b0); ex_flush = 1'b1; ex_entry = 32'h1c008000;
        br_taken = 1'b1; br_target = 32'h1c000200;
        cyc(); chk("ex_cancel", {31'd0, to_cancel}, 32'd1); adv();
        set_in(1'b1, 1'b1); cyc(); chk("ex_addr", inst_sram_addr, 32'h1c008000); adv();

        // Misaligned branch target flagged, then +4 from it.
        set_in(1'b1, 1'b1); br_taken = 1'b1; br_target = 32'h1c000102;
        cyc(); chk("adef_pc", pc, 32'h1c000102); adv();
        set_in(1'b1, 1'b1); cyc(); chk("adef_next", inst_sram_addr, 32'h1c000106); adv();

        // Address wrap.
        set_in(1'b1, 1'b1); br_taken = 1'b1; br_target = 32'hfffffffc; cyc(); adv();
        set_in(1'b1, 1'b1); cyc(); chk("wrap", inst_sram_addr, 32'h00000000); adv();

        // Reset while holding discards everything.
        set_in(1'b1, 1'b0); cyc(); adv();
        reset = 1'b1; cyc(); adv(); reset = 1'b0;
        set_in(1'b1, 1'b1); cyc(); chk("rst_hold", inst_sram_addr, RST_PC); adv();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            set_in(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
            br_taken   = ($urandom_range(0, 7) == 0);
            ertn_flush = ($urandom_range(0, 11) == 0);
            ex_flush   = ($urandom_range(0, 15) == 0);
            br_target  = $urandom & 32'hfffffffc;
            era        = $urandom & 32'hfffffffc;
            ex_entry   = $urandom & 32'hfffffffc;
            if ($urandom_range(0, 3) == 0) br_target = br_target | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) era = era | 32'd2;
            cyc(); adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_preif.md
PIPE_PREIF -- requirements
Module: pipe_preif

Interface
REQ-001 Parameter RESET_PC, default 32'h1c000000, first fetch address after reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 to_allowin  input  1  IF stage can accept a PC this cycle.
REQ-005 to_valid  output  1  preIF holds a PC that IF may latch.
REQ-006 pc  output  32  PC offered to IF, qualified by to_valid.
REQ-007 adef  output  1  offered PC is misaligned (pc[1:0]!=0), qualified by to_valid.
REQ-008 br_taken / br_target  input  1 / 32  branch redirect from a later stage, single-cycle pulse.
REQ-009 ertn_flush / era  input  1 / 32  exception-return redirect, pulse.
REQ-010 ex_flush / ex_entry  input  1 / 32  exception redirect, pulse.
REQ-011 inst_sram_req  output  1  instruction SRAM request.
REQ-012 inst_sram_addr  output  32  request address.
REQ-013 inst_sram_addr_ok  input  1  SRAM accepts the request this cycle.
REQ-014 to_cancel  output  1  one-cycle pulse: IF shall discard the next returning instruction word.

Function
REQ-015 Two states: REQ (issuing) and HOLD (request accepted, waiting for IF).
REQ-016 Internal regs: last_pc (32, last PC handed off or accepted), redir_valid/redir_pc (buffered redirect), held_pc/held_adef.
REQ-017 nextpc priority: ex_flush->ex_entry; else ertn_flush->era; else br_taken->br_target; else redir_valid->redir_pc; else last_pc+4 (mod 2^32, wraps silently).
REQ-018 In REQ: inst_sram_req = !nextpc_misaligned; inst_sram_addr = nextpc; pc = nextpc; adef = nextpc[1:0]!=0.
REQ-019 In REQ: handshake = (inst_sram_req && inst_sram_addr_ok) || adef; to_valid = handshake.
REQ-020 On handshake: last_pc <= nextpc; redir_valid <= 0; if to_allowin stay REQ, else held_pc <= nextpc, held_adef <= adef, go HOLD.
REQ-021 In REQ, redirect input asserted without handshake: redir_valid <= 1, redir_pc <= selected target; next cycle retries with it.
REQ-022 In HOLD: inst_sram_req = 0; pc = held_pc; adef = held_adef; to_valid = 1 unless a redirect input is asserted; to_allowin -> REQ.
REQ-023 In HOLD with any redirect asserted (regardless of to_allowin): to_valid = 0; redir buffer loaded; go REQ; to_cancel = 1 this cycle iff !held_adef.
REQ-024 to_cancel is 0 in all other cycles.
REQ-025 Simultaneous redirects: only highest-priority target used/buffered; a new redirect overwrites an existing buffered one.
REQ-026 Handshake and redirect in same REQ cycle: address is the redirect target directly; buffer not loaded.
REQ-027 Latency: PC offered in the same cycle addr_ok is seen; zero bubbles for back-to-back addr_ok with to_allowin=1.
REQ-028 Misaligned PC never drives inst_sram_req; passes to IF flagged adef; sequential PC continues from it (+4).

Reset
REQ-029 reset: state=REQ, last_pc=RESET_PC-4, redir_valid=0, redir_pc=0, held_pc=0, held_adef=0.
REQ-030 While reset=1: to_valid=0, inst_sram_req=0, to_cancel=0, adef=0; pc=RESET_PC.
REQ-031 Reset mid-HOLD or with buffered redirect: all state discarded; first cycle after reset requests RESET_PC.

Verification
REQ-032 Release reset, addr_ok=1, to_allowin=1 every cycle -> addresses 1c000000, 1c000004, 1c000008 on consecutive cycles, to_valid=1 each.
REQ-033 addr_ok=1, to_allowin=0 for 3 cycles at PC 1c000010 -> HOLD, pc=1c000010 steady, req=0; to_allowin=1 -> next req 1c000014.
REQ-034 addr_ok=0, br_taken=1 target 1c000100 one cycle, addr_ok=1 two cycles later -> req addr 1c000100, buffered until then, to_valid only on accept.
REQ-035 In HOLD, ex_flush=1 entry 1c008000 with br_taken=1 same cycle -> to_valid=0, to_cancel=1, next req 1c008000.
REQ-036 br_target 1c000102 -> no req, to_valid=1, adef=1, pc=1c000102; next req 1c000106.
REQ-037 last_pc=ffffffff-3 (fffffffc) sequential -> next req 00000000.
